track_renderer: RTL and testbench
=================================

TRACK_RENDERER -- requirements
Module: track_renderer

Interface
REQ-001 The block SHALL have parameter WINDOW_W, default 160, meaning scaled columns per line.
REQ-002 The block SHALL have parameter HORIZON, default 60, meaning the first scaled row of track.
REQ-003 The block SHALL have parameter SCALE, default 2, meaning log2 screen pixels per scaled pixel, both axes.
REQ-004 The block SHALL have parameter LANES, default 3, meaning the lane count (LANES-1 markers max), range 1..8.
REQ-005 The block SHALL have parameter ADDR_W, default 9, meaning the vram_addr width.
REQ-006 The block SHALL have ports pixel_clk input 1, the pixel clock; Reset input 1, asynchronous active-high reset, one clock only.
REQ-007 The block SHALL have ports DrawX input 10 and DrawY input 10, the screen coordinates.
REQ-008 The block SHALL have port isTrack input 1, high while DrawY lies in the track region.
REQ-009 The block SHALL have port track_desc input 40, the line descriptor: [39] stripe, [38:29] left_x, [28:23] curb_w, [22:13] road_w, [12:3] lane_pitch, [2:0] mark_w.
REQ-010 The block SHALL have ports red, green and blue, each output 4, the registered colour.
REQ-011 The block SHALL have port vram_addr output ADDR_W, the descriptor address for the next scanline.

Function
REQ-012 DrawXS=DrawX>>SCALE and DrawYS=DrawY>>SCALE SHALL be used; state SHALL advance only on the pixel_clk where DrawX[SCALE-1:0]==0 (the scaled-column step).
REQ-013 Segment states SHALL be FAR, GRASS_L, CURB_L, ROAD, MARK, CURB_R, GRASS_R.
REQ-014 isTrack low SHALL force FAR on the next step, with sky colour 0,0,F.
REQ-015 A step with isTrack high and DrawXS==0 SHALL latch track_desc into a line register and enter the first non-zero-width segment of GRASS_L(left_x), CURB_L(curb_w), ROAD(road_w), CURB_R(curb_w), GRASS_R.
REQ-016 A down-counter SHALL be loaded with each segment width; at count 1 the next step SHALL enter the next non-zero-width segment; zero-width segments SHALL be skipped in the same step.
REQ-017 Any segment reaching DrawXS==WINDOW_W-1 SHALL be clipped, and the line SHALL end; GRASS_R SHALL persist until the next line start.
REQ-018 Inside ROAD, a lane counter SHALL count to lane_pitch and then enter MARK for mark_w steps, returning to ROAD with the remaining road width decremented during MARK too; at most LANES-1 markers per line.
REQ-019 lane_pitch==0 or mark_w==0 SHALL suppress markers.
REQ-020 Colours SHALL be: grass 0,F,0; curb F,F,F if stripe else F,0,0; road 3,3,3; MARK F,F,F if stripe else 3,3,3.
REQ-021 red/green/blue SHALL be registered with latency exactly 1 pixel_clk from the step that determines the state.
REQ-022 vram_addr SHALL update at DrawXS==WINDOW_W-1 while isTrack, to (DrawYS+1-HORIZON) truncated to ADDR_W, and SHALL otherwise hold its value.
REQ-023 If isTrack falls mid-line, FAR SHALL take effect on the next step, and the line register SHALL hold.

Reset
REQ-024 Reset SHALL force state FAR, all counters 0, the line register 0, red/green/blue 0, and vram_addr 0, asynchronously.
REQ-025 After Reset deasserts, the first DrawXS==0 step with isTrack high SHALL start a normal line; partial lines SHALL render FAR.

Configuration
REQ-026 With macro TRACK_LANE_MARK_EN defined, MARK and the lane counter SHALL exist per REQ-018.
REQ-027 Without TRACK_LANE_MARK_EN, MARK and the lane counter SHALL be absent, ROAD SHALL be uniform, and lane_pitch/mark_w SHALL be ignored.

Structure
REQ-028 Package track_pkg SHALL hold the seg_t enum, the colour constants, and the descriptor field offsets/widths.
REQ-029 Sub-module lane_marker SHALL contain the lane counter and marker count, compiled only under TRACK_LANE_MARK_EN.

Verification
REQ-030 The bench SHALL apply Reset mid-line and check RGB=0 and vram_addr=0 immediately, with FAR until the next line start.
REQ-031 The bench SHALL apply a descriptor with left_x=20, curb_w=4, road_w=60, lane_pitch=0, stripe=0 and check grass at DrawXS 0-19, red 20-23, road 24-83, red 84-87, and grass 88-159, each one clock late.
REQ-032 The bench SHALL apply a descriptor with left_x=0, curb_w=0, road_w=200 and check road from column 0 clipped at 159, with no curbs.
REQ-033 The bench SHALL apply road_w=60, lane_pitch=18, mark_w=2, stripe=1, LANES=3 and check white at road offsets 18-19 and 38-39, no third marker, and curbs white.
REQ-034 The bench SHALL drive DrawYS=100 at DrawXS=159 with isTrack high and check vram_addr=41; with isTrack low, vram_addr SHALL be unchanged.
REQ-035 The bench SHALL build without TRACK_LANE_MARK_EN, rerun REQ-033, and check a uniform 3,3,3 road.

Source files
------------

// File: rtl/track_pkg.sv
// ---------------------------------------------------------------------------
// track_pkg : segment enum, colours and descriptor layout for track_renderer
// Rev 1.0 -- MARK exists only with TRACK_LANE_MARK_EN
// ---------------------------------------------------------------------------
`default_nettype none

package track_pkg;

`ifdef TRACK_LANE_MARK_EN
  typedef enum logic [2:0] {
    FAR     = 3'd0,
    GRASS_L = 3'd1,
    CURB_L  = 3'd2,
    ROAD    = 3'd3,
    CURB_R  = 3'd4,
    GRASS_R = 3'd5,
    MARK    = 3'd6
  } seg_t;
`else
  typedef enum logic [2:0] {
    FAR     = 3'd0,
    GRASS_L = 3'd1,
    CURB_L  = 3'd2,
    ROAD    = 3'd3,
    CURB_R  = 3'd4,
    GRASS_R = 3'd5
  } seg_t;
`endif

  localparam int DESC_W     = 40;
  localparam int STRIPE_BIT = 39;
  localparam int LEFT_LSB   = 29;
  localparam int LEFT_W     = 10;
  localparam int CURB_LSB   = 23;
  localparam int CURB_W     = 6;
  localparam int ROAD_LSB   = 13;
  localparam int ROAD_W     = 10;
  localparam int PITCH_LSB  = 3;
  localparam int PITCH_W    = 10;
  localparam int MARKW_LSB  = 0;
  localparam int MARKW_W    = 3;
  localparam int CNT_W      = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t C_BLACK = 12'h000;
  localparam rgb_t C_SKY   = 12'h00F;
  localparam rgb_t C_GRASS = 12'h0F0;
  localparam rgb_t C_RED   = 12'hF00;
  localparam rgb_t C_WHITE = 12'hFFF;
  localparam rgb_t C_ROAD  = 12'h333;

  typedef struct packed {
    seg_t             seg;
    logic [CNT_W-1:0] width;
  } seg_load_t;

  // Segment order index: 0 GRASS_L, 1 CURB_L, 2 ROAD, 3 CURB_R, 4 GRASS_R.
  function automatic seg_load_t first_seg(input logic [2:0]       from_idx,
                                          input logic [CNT_W-1:0] left_w,
                                          input logic [CNT_W-1:0] curb_w,
                                          input logic [CNT_W-1:0] road_w);
    seg_load_t res;
    res.seg   = GRASS_R;
    res.width = '0;
    if (from_idx == 3'd0 && left_w != '0) begin
      res.seg   = GRASS_L;
      res.width = left_w;
    end else if (from_idx <= 3'd1 && curb_w != '0) begin
      res.seg   = CURB_L;
      res.width = curb_w;
    end else if (from_idx <= 3'd2 && road_w != '0) begin
      res.seg   = ROAD;
      res.width = road_w;
    end else if (from_idx <= 3'd3 && curb_w != '0) begin
      res.seg   = CURB_R;
      res.width = curb_w;
    end
    return res;
  endfunction

  function automatic logic [2:0] next_idx(input seg_t s);
    logic [2:0] idx;
    case (s)
      GRASS_L: idx = 3'd1;
      CURB_L:  idx = 3'd2;
      ROAD:    idx = 3'd3;
`ifdef TRACK_LANE_MARK_EN
      MARK:    idx = 3'd3;
`endif
      default: idx = 3'd4;
    endcase
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_marker.sv
// ---------------------------------------------------------------------------
// lane_marker : lane spacing counter and per-line marker budget (TRACK_LANE_MARK_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifdef TRACK_LANE_MARK_EN
module lane_marker
  import track_pkg::*;
#(
  parameter int LANES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic               line_start,
  input  seg_t               seg_q,
  input  seg_t               seg_d,
  input  logic [PITCH_W-1:0] lane_pitch,
  input  logic [MARKW_W-1:0] mark_w,
  output logic               mark_go,
  output logic               mark_done
);

  logic [PITCH_W-1:0] lane_q, lane_d;
  logic [MARKW_W-1:0] mk_q, mk_d;
  logic [3:0]         used_q, used_d;

  always_comb begin
    lane_d = lane_q;
    mk_d   = mk_q;
    used_d = used_q;
    if (step) begin
      if (line_start) used_d = '0;
      // Lane distance restarts at 1 on every (re)entry into ROAD.
      if (seg_d == ROAD) begin
        lane_d = (seg_q == ROAD && !line_start) ? lane_q + PITCH_W'(1) : PITCH_W'(1);
      end
      if (seg_d == MARK) begin
        if (seg_q == MARK) begin
          mk_d = mk_q - MARKW_W'(1);
        end else begin
          mk_d   = mark_w;
          used_d = used_q + 4'd1;
        end
      end
    end
  end

  assign mark_go = (seg_q == ROAD) && (lane_pitch != '0) && (mark_w != '0) &&
                   (lane_q == lane_pitch) && (used_q < 4'(LANES - 1));
  assign mark_done = (seg_q == MARK) && (mk_q == MARKW_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      mk_q   <= '0;
      used_q <= '0;
    end else begin
      lane_q <= lane_d;
      mk_q   <= mk_d;
      used_q <= used_d;
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/track_renderer.sv
// ---------------------------------------------------------------------------
// track_renderer : per-scanline segment FSM producing registered track colour
// Rev 1.0 -- lane markers enabled by macro TRACK_LANE_MARK_EN
// ---------------------------------------------------------------------------
`default_nettype none

module track_renderer
  import track_pkg::*;
#(
  parameter int WINDOW_W = 160,
  parameter int HORIZON  = 60,
  parameter int SCALE    = 2,
  parameter int LANES    = 3,
  parameter int ADDR_W   = 9
) (
  input  logic              pixel_clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              isTrack,
  input  logic [39:0]       track_desc,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic [ADDR_W-1:0] vram_addr
);

  localparam int SUM_W = (ADDR_W > 11) ? ADDR_W : 11;

  logic [9:0] draw_xs;
  logic [9:0] draw_ys;
  logic       step;
  logic       line_start;

  assign draw_xs = DrawX >> SCALE;
  assign draw_ys = DrawY >> SCALE;

  generate
    if (SCALE == 0) begin : g_step_every
      assign step = 1'b1;
    end else begin : g_step_scaled
      assign step = (DrawX[SCALE-1:0] == '0);
    end
  endgenerate

  seg_t              seg_q, seg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DESC_W-1:0] line_q, line_d;
  rgb_t              rgb_q, rgb_d;
  logic [ADDR_W-1:0] vram_q, vram_d;
  logic [SUM_W-1:0]  vram_sum;
  seg_load_t         start_ld, adv_ld;

  assign line_start = step && isTrack && (draw_xs == '0);
  assign vram_sum   = SUM_W'(draw_ys) + SUM_W'(1) - SUM_W'(HORIZON);

  assign start_ld = first_seg(3'd0,
                              CNT_W'(track_desc[LEFT_LSB +: LEFT_W]),
                              CNT_W'(track_desc[CURB_LSB +: CURB_W]),
                              CNT_W'(track_desc[ROAD_LSB +: ROAD_W]));
  assign adv_ld = first_seg(next_idx(seg_q),
                            CNT_W'(line_q[LEFT_LSB +: LEFT_W]),
                            CNT_W'(line_q[CURB_LSB +: CURB_W]),
                            CNT_W'(line_q[ROAD_LSB +: ROAD_W]));

`ifdef TRACK_LANE_MARK_EN
  logic mark_go;
  logic mark_done;

  lane_marker #(
    .LANES(LANES)
  ) u_lane_marker (
    .clk        (pixel_clk),
    .rst        (Reset),
    .step       (step),
    .line_start (line_start),
    .seg_q      (seg_q),
    .seg_d      (seg_d),
    .lane_pitch (line_q[PITCH_LSB +: PITCH_W]),
    .mark_w     (line_q[MARKW_LSB +: MARKW_W]),
    .mark_go    (mark_go),
    .mark_done  (mark_done)
  );
`else
  logic unused_lane_fields;
  assign unused_lane_fields = ^line_q[PITCH_LSB + PITCH_W - 1:MARKW_LSB];
`endif

  always_comb begin
    seg_d  = seg_q;
    cnt_d  = cnt_q;
    line_d = line_q;
    vram_d = vram_q;
    if (step) begin
      if (!isTrack) begin
        seg_d = FAR;
      end else if (draw_xs == '0) begin
        line_d = track_desc;
        seg_d  = start_ld.seg;
        cnt_d  = start_ld.width;
      end else if (seg_q == FAR || seg_q == GRASS_R) begin
        seg_d = seg_q;
      end else if (draw_xs >= 10'(WINDOW_W)) begin
        seg_d = GRASS_R;
      end else if (cnt_q == CNT_W'(1)) begin
        seg_d = adv_ld.seg;
        cnt_d = adv_ld.width;
      end else begin
        // ROAD and MARK share one count so markers eat into the road width.
        cnt_d = cnt_q - CNT_W'(1);
`ifdef TRACK_LANE_MARK_EN
        if (seg_q == ROAD && mark_go) begin
          seg_d = MARK;
        end else if (seg_q == MARK && mark_done) begin
          seg_d = ROAD;
        end
`endif
      end
      if (isTrack && draw_xs == 10'(WINDOW_W - 1)) begin
        vram_d = vram_sum[ADDR_W-1:0];
      end
    end
  end

  always_comb begin
    rgb_d = C_SKY;
    case (seg_q)
      GRASS_L, GRASS_R: rgb_d = C_GRASS;
      CURB_L, CURB_R:   rgb_d = line_q[STRIPE_BIT] ? C_WHITE : C_RED;
      ROAD:             rgb_d = C_ROAD;
`ifdef TRACK_LANE_MARK_EN
      MARK:             rgb_d = line_q[STRIPE_BIT] ? C_WHITE : C_ROAD;
`endif
      default:          rgb_d = C_SKY;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge Reset) begin
    if (Reset) begin
      seg_q  <= FAR;
      cnt_q  <= '0;
      line_q <= '0;
      rgb_q  <= C_BLACK;
      vram_q <= '0;
    end else begin
      seg_q  <= seg_d;
      cnt_q  <= cnt_d;
      line_q <= line_d;
      rgb_q  <= rgb_d;
      vram_q <= vram_d;
    end
  end

  assign red       = rgb_q.r;
  assign green     = rgb_q.g;
  assign blue      = rgb_q.b;
  assign vram_addr = vram_q;

endmodule

`default_nettype wire

// File: tb/tb_track_renderer.sv
// ---------------------------------------------------------------------------
// tb_track_renderer : directed scanline vectors for track_renderer
// Rev 1.0 -- expectations follow TRACK_LANE_MARK_EN when defined
// ---------------------------------------------------------------------------
`default_nettype none

module tb_track_renderer;

  localparam logic [11:0] SKY = 12'h00F;
  localparam logic [11:0] GRN = 12'h0F0;
  localparam logic [11:0] RED = 12'hF00;
  localparam logic [11:0] WHT = 12'hFFF;
  localparam logic [11:0] GRY = 12'h333;

  logic        pixel_clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        isTrack;
  logic [39:0] track_desc;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic [8:0]  vram_addr;

  always #5 pixel_clk = ~pixel_clk;

  track_renderer dut (
    .pixel_clk  (pixel_clk),
    .Reset      (Reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .isTrack    (isTrack),
    .track_desc (track_desc),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .vram_addr  (vram_addr)
  );

  typedef struct {
    logic [39:0] d;
    int          ys;
    int          drop;
    int          rst_x;
    int          vram;
  } line_t;

  typedef struct {
    int          id;
    int          lo;
    int          hi;
    logic [11:0] rgb;
  } range_t;

  line_t       lines[$];
  range_t      rng[$];
  logic [11:0] got[0:159];
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [39:0] make_desc(input int stripe, input int left, input int curb,
                                            input int road, input int pitch, input int markw);
    return {1'(stripe), 10'(left), 6'(curb), 10'(road), 10'(pitch), 3'(markw)};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got_v,
                     input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s idx=%0d got=%0h expected=%0h", name, idx, got_v, exp_v);
    end
  endtask

  task automatic add(input int id, input int lo, input int hi, input logic [11:0] c);
    rng.push_back('{id, lo, hi, c});
  endtask

  task automatic add_d1(input int id);
    add(id, 0, 19, GRN);
    add(id, 20, 23, RED);
    add(id, 24, 83, GRY);
    add(id, 84, 87, RED);
    add(id, 88, 159, GRN);
  endtask

  // One full 800-clock scanline; colour for scaled column k is captured
  // two clocks after its step, i.e. one clock after the register update.
  task automatic render_line(input logic [39:0] d, input int ys, input int drop, input int rst_x);
    track_desc = d;
    DrawY      = 10'(ys * 4);
    for (int x = 0; x < 800; x++) begin
      @(negedge pixel_clk);
      Reset = 1'b0;
      if ((x % 4) == 2 && (x / 4) < 160) got[x / 4] = {red, green, blue};
      if (x == rst_x) begin
        #2 Reset = 1'b1;
        #1;
        chk("midline_reset_rgb", x, 32'({red, green, blue}), 32'h0);
        chk("midline_reset_vram", x, 32'(vram_addr), 32'h0);
      end
      DrawX   = 10'(x);
      isTrack = ((x / 4) < drop);
    end
  endtask

  initial begin
    logic [39:0] d1;
    logic [39:0] d2;
    logic [39:0] d3;

    Reset      = 1'b1;
    DrawX      = '0;
    DrawY      = '0;
    isTrack    = 1'b0;
    track_desc = '0;

    d1 = make_desc(0, 20, 4, 60, 0, 0);
    d2 = make_desc(0, 0, 0, 200, 0, 0);
    d3 = make_desc(1, 20, 4, 60, 18, 2);

    lines.push_back('{d1, 10, 1000, -1, 463});
    lines.push_back('{d2, 20, 1000, -1, 473});
    lines.push_back('{d3, 30, 1000, -1, 483});
    lines.push_back('{d1, 40, 50, -1, 483});
    lines.push_back('{d1, 100, 1000, -1, 41});
    lines.push_back('{d1, 120, 0, -1, 41});
    lines.push_back('{d1, 61, 1000, 202, 2});
    lines.push_back('{d1, 62, 1000, -1, 3});

    add_d1(0);
    add(1, 0, 159, GRY);
    add(2, 0, 19, GRN);
    add(2, 20, 23, WHT);
`ifdef TRACK_LANE_MARK_EN
    add(2, 24, 41, GRY);
    add(2, 42, 43, WHT);
    add(2, 44, 61, GRY);
    add(2, 62, 63, WHT);
    add(2, 64, 83, GRY);
`else
    add(2, 24, 83, GRY);
`endif
    add(2, 84, 87, WHT);
    add(2, 88, 159, GRN);
    add(3, 0, 19, GRN);
    add(3, 20, 23, RED);
    add(3, 24, 49, GRY);
    add(3, 50, 159, SKY);
    add_d1(4);
    add(5, 0, 159, SKY);
    add(6, 0, 19, GRN);
    add(6, 20, 23, RED);
    add(6, 24, 50, GRY);
    add(6, 51, 159, SKY);
    add_d1(7);

    repeat (3) @(negedge pixel_clk);
    chk("reset_rgb", 0, 32'({red, green, blue}), 32'h0);
    chk("reset_vram", 0, 32'(vram_addr), 32'h0);
    Reset = 1'b0;

    for (int t = 0; t < lines.size(); t++) begin
      render_line(lines[t].d, lines[t].ys, lines[t].drop, lines[t].rst_x);
      for (int r = 0; r < rng.size(); r++) begin
        if (rng[r].id == t) begin
          for (int c = rng[r].lo; c <= rng[r].hi; c++) begin
            chk($sformatf("line%0d_col", t), c, 32'(got[c]), 32'(rng[r].rgb));
          end
        end
      end
      chk($sformatf("line%0d_vram", t), t, 32'(vram_addr), 32'(lines[t].vram));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
